// File: rtl/audio_frame_sequencer.sv
// Sample-rate pacer for the synth-to-codec path: each sample period it scans the voice
// slots over a shared req/ack port, sums the active voices and writes one saturated stereo word.
module audio_frame_sequencer #(
  parameter int NUM_VOICES  = 8,
  parameter int VIDX_W      = 3,
  parameter int SAMPLE_W    = 16,
  parameter int CLK_DIV     = 1042,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [NUM_VOICES-1:0] voice_active,
  output logic                  voice_req,
  output logic [VIDX_W-1:0]     voice_sel,
  input  logic                  voice_ack,
  input  logic [SAMPLE_W-1:0]   voice_sample,
  input  logic                  audio_out_allowed,
  output logic                  write_audio_out,
  output logic [31:0]           left_channel_audio_out,
  output logic [31:0]           right_channel_audio_out,
  output logic                  sample_tick,
  output logic                  busy,
  output logic [15:0]           underrun_count
);

  localparam int ACC_W = SAMPLE_W + VIDX_W;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [TMO_W-1:0]        TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [VIDX_W-1:0]       IDX_LAST = VIDX_W'(NUM_VOICES - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = {{(VIDX_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN  = {{(VIDX_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, REQ, SAT, WRITE} state_e;

  state_e                   state_q, state_d;
  logic [DIV_W-1:0]         div_q, div_d;
  logic [VIDX_W-1:0]        idx_q, idx_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [SAMPLE_W-1:0]      mix_q, mix_d;
  logic                     write_q, write_d;
  logic [15:0]              underrun_q, underrun_d;

  logic                     div_last;
  logic                     slot_done;
  logic signed [ACC_W-1:0]  sample_ext;

  assign div_last    = (div_q == DIV_LAST);
  assign sample_tick = enable & div_last;
  assign sample_ext  = {{VIDX_W{voice_sample[SAMPLE_W-1]}}, voice_sample};

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred; blocking '=' is correct in combinational logic.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    acc_d      = acc_q;
    mix_d      = mix_q;
    write_d    = 1'b0;
    underrun_d = underrun_q;
    voice_req  = 1'b0;
    slot_done  = 1'b0;

    if (!enable)       div_d = '0;
    else if (div_last) div_d = '0;
    else               div_d = div_q + 1'b1;

    // A tick that lands mid-frame is dropped and counted; the frame finishes normally.
    if (sample_tick && state_q != IDLE && underrun_q != 16'hFFFF)
      underrun_d = underrun_q + 16'd1;

    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sample_tick) begin
            acc_d   = '0;
            idx_d   = '0;
            tmo_d   = '0;
            state_d = REQ;
          end
        end
        REQ: begin
          // voice_active only matters on a slot's first cycle (tmo_q == 0).
          if (tmo_q == '0 && !voice_active[idx_q]) begin
            slot_done = 1'b1;
          end else begin
            voice_req = 1'b1;
            if (voice_ack) begin
              acc_d     = acc_q + sample_ext;
              slot_done = 1'b1;
            end else if (tmo_q == TMO_LAST) begin
              slot_done = 1'b1;
            end else begin
              tmo_d = tmo_q + 1'b1;
            end
          end
          if (slot_done) begin
            tmo_d = '0;
            if (idx_q == IDX_LAST) state_d = SAT;
            else                   idx_d   = idx_q + 1'b1;
          end
        end
        SAT: begin
          if (acc_q > SAT_MAX)      mix_d = SAT_MAX[SAMPLE_W-1:0];
          else if (acc_q < SAT_MIN) mix_d = SAT_MIN[SAMPLE_W-1:0];
          else                      mix_d = acc_q[SAMPLE_W-1:0];
          state_d = WRITE;
        end
        WRITE: begin
          if (audio_out_allowed) begin
            write_d = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      idx_q      <= '0;
      tmo_q      <= '0;
      acc_q      <= '0;
      mix_q      <= '0;
      write_q    <= 1'b0;
      underrun_q <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      acc_q      <= acc_d;
      mix_q      <= mix_d;
      write_q    <= write_d;
      underrun_q <= underrun_d;
    end
  end

  assign voice_sel               = idx_q;
  assign write_audio_out         = write_q;
  assign left_channel_audio_out  = {mix_q, {(32-SAMPLE_W){1'b0}}};
  assign right_channel_audio_out = {mix_q, {(32-SAMPLE_W){1'b0}}};
  assign busy                    = (state_q != IDLE);
  assign underrun_count          = underrun_q;

endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Directed bench for audio_frame_sequencer: pacing, mixing/saturation, ack timeout,
// back-pressure underrun, enable drop and async reset, with a per-slot voice responder.
module tb_audio_frame_sequencer;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [7:0]  voice_active;
  logic        voice_req;
  logic [2:0]  voice_sel;
  logic        voice_ack;
  logic [15:0] voice_sample;
  logic        audio_out_allowed;
  logic        write_audio_out;
  logic [31:0] left_out;
  logic [31:0] right_out;
  logic        sample_tick;
  logic        busy;
  logic [15:0] underrun_count;

  int total = 0;
  int bad   = 0;

  int          dly [8];
  logic [15:0] val [8];
  int          req_cycles [8];
  logic [31:0] wr_left, wr_right;

  audio_frame_sequencer dut (
    .CLOCK_50                (clk),
    .reset_n                 (reset_n),
    .enable                  (enable),
    .voice_active            (voice_active),
    .voice_req               (voice_req),
    .voice_sel               (voice_sel),
    .voice_ack               (voice_ack),
    .voice_sample            (voice_sample),
    .audio_out_allowed       (audio_out_allowed),
    .write_audio_out         (write_audio_out),
    .left_channel_audio_out  (left_out),
    .right_channel_audio_out (right_out),
    .sample_tick             (sample_tick),
    .busy                    (busy),
    .underrun_count          (underrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Acts as the voice datapath: acks slot s dly[s] cycles after its request rises
  // (dly < 0 = never). Returns at the first write strobe or after max_cyc cycles.
  task automatic serve_frame(input int max_cyc, output bit wrote);
    int         wait_cnt;
    bit         in_wait;
    logic [2:0] cur_sel;
    wrote    = 1'b0;
    in_wait  = 1'b0;
    wait_cnt = 0;
    cur_sel  = '0;
    for (int s = 0; s < 8; s++) req_cycles[s] = 0;
    for (int n = 0; n < max_cyc && !wrote; n++) begin
      @(negedge clk);
      voice_ack = 1'b0;
      if (write_audio_out) begin
        wrote    = 1'b1;
        wr_left  = left_out;
        wr_right = right_out;
      end else if (voice_req) begin
        if (!in_wait || voice_sel != cur_sel) begin
          cur_sel  = voice_sel;
          wait_cnt = 0;
          in_wait  = 1'b1;
        end else begin
          wait_cnt++;
        end
        req_cycles[cur_sel]++;
        if (dly[cur_sel] >= 0 && wait_cnt == dly[cur_sel]) begin
          voice_ack    = 1'b1;
          voice_sample = val[cur_sel];
        end
      end else begin
        in_wait = 1'b0;
      end
    end
    voice_ack = 1'b0;
  endtask

  task automatic set_voices(input logic [7:0] act, input logic [15:0] v, input int d);
    voice_active = act;
    for (int s = 0; s < 8; s++) begin
      val[s] = v;
      dly[s] = d;
    end
  endtask

  initial begin
    bit wrote;
    int first_tick, second_tick, first_write, ticks, writes, hit;
    logic busy_mid;

    reset_n = 1'b0; enable = 1'b0; voice_active = '0; voice_ack = 1'b0;
    voice_sample = '0; audio_out_allowed = 1'b1;
    set_voices(8'h00, 16'h0000, 0);
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_req",      voice_req, 0);
    check("rst_sel",      voice_sel, 0);
    check("rst_write",    write_audio_out, 0);
    check("rst_left",     left_out, 0);
    check("rst_right",    right_out, 0);
    check("rst_tick",     sample_tick, 0);
    check("rst_busy",     busy, 0);
    check("rst_underrun", underrun_count, 0);

    // Test 1: pacing and all-inactive latency
    reset_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    first_tick = -1; second_tick = -1; first_write = -1; ticks = 0; writes = 0;
    busy_mid = 1'b0;
    for (int n = 1; n <= 2100; n++) begin
      @(negedge clk);
      if (sample_tick) begin
        ticks++;
        if (first_tick < 0) first_tick = n;
        else if (second_tick < 0) second_tick = n;
      end
      if (write_audio_out) begin
        writes++;
        if (first_write < 0) first_write = n;
      end
      if (n == 1045) busy_mid = busy;
    end
    check("t1_first_tick",  first_tick, 1041);
    check("t1_second_tick", second_tick, 2083);
    check("t1_tick_count",  ticks, 2);
    check("t1_first_write", first_write, 1052);
    check("t1_write_count", writes, 2);
    check("t1_busy_mid",    busy_mid, 1);
    check("t1_left_zero",   left_out, 0);

    // Test 2: slot 0 only, ack 3 cycles after request
    set_voices(8'h01, 16'h1000, 3);
    serve_frame(2500, wrote);
    check("t2_wrote",   wrote, 1);
    check("t2_left",    wr_left, 32'h1000_0000);
    check("t2_right",   wr_right, 32'h1000_0000);
    check("t2_req_len", req_cycles[0], 4);
    check("t2_req_s1",  req_cycles[1], 0);
    @(negedge clk);
    check("t2_wr_pulse", write_audio_out, 0);

    // Test 3: saturation high, saturation low, mixed signs
    set_voices(8'hFF, 16'h2000, 0);
    serve_frame(2500, wrote);
    check("t3a_wrote", wrote, 1);
    check("t3a_left",  wr_left, 32'h7FFF_0000);
    check("t3a_req7",  req_cycles[7], 1);

    set_voices(8'hFF, 16'hE000, 0);
    serve_frame(2500, wrote);
    check("t3b_wrote", wrote, 1);
    check("t3b_left",  wr_left, 32'h8000_0000);
    check("t3b_right", wr_right, 32'h8000_0000);

    set_voices(8'h03, 16'h0000, 1);
    val[0] = 16'h1000;
    val[1] = 16'hF800;
    serve_frame(2500, wrote);
    check("t3c_wrote", wrote, 1);
    check("t3c_left",  wr_left, 32'h0800_0000);

    // Test 4: slot 2 never acks, slots 0 and 3 contribute
    set_voices(8'h0D, 16'h0100, 0);
    val[2] = 16'h7000;
    dly[2] = -1;
    serve_frame(2500, wrote);
    check("t4_wrote",    wrote, 1);
    check("t4_req2_len", req_cycles[2], 64);
    check("t4_left",     wr_left, 32'h0200_0000);
    check("t4_underrun", underrun_count, 0);

    // Test 5: back-pressure across a tick
    set_voices(8'h01, 16'h0123, 0);
    audio_out_allowed = 1'b0;
    hit = 0;
    for (int n = 0; n < 1100 && hit == 0; n++) begin
      @(negedge clk);
      if (sample_tick) hit = 1;
    end
    check("t5_tick_seen", hit, 1);
    serve_frame(1109, wrote);
    check("t5_no_write", wrote, 0);
    check("t5_underrun", underrun_count, 1);
    check("t5_busy",     busy, 1);
    check("t5_held",     left_out, 32'h0123_0000);
    audio_out_allowed = 1'b1;
    hit = 0;
    for (int n = 1; n <= 5 && hit == 0; n++) begin
      @(negedge clk);
      if (write_audio_out) hit = n;
    end
    check("t5_write_lat", hit, 1);
    check("t5_write_data", left_out, 32'h0123_0000);
    @(negedge clk);
    check("t5_wr_pulse", write_audio_out, 0);

    // Enable dropped while a slot is waiting
    set_voices(8'h01, 16'h4000, -1);
    hit = 0;
    for (int n = 0; n < 1200 && hit == 0; n++) begin
      @(negedge clk);
      if (voice_req) hit = 1;
    end
    check("t6a_req_seen", hit, 1);
    enable = 1'b0;
    @(negedge clk);
    check("t6a_req_drop",  voice_req, 0);
    check("t6a_busy_drop", busy, 0);
    check("t6a_mix_kept",  left_out, 32'h0123_0000);
    writes = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (write_audio_out) writes++;
    end
    check("t6a_no_write", writes, 0);

    // Test 6: re-enable restarts the divider; async reset during a slot wait
    enable = 1'b1;
    first_tick = -1;
    for (int n = 1; n <= 1100 && first_tick < 0; n++) begin
      @(negedge clk);
      if (sample_tick) first_tick = n;
    end
    check("t6_tick_restart", first_tick, 1041);
    hit = 0;
    for (int n = 0; n < 5 && hit == 0; n++) begin
      @(negedge clk);
      if (voice_req) hit = 1;
    end
    check("t6_req_seen", hit, 1);
    repeat (3) @(negedge clk);
    check("t6_req_wait",     voice_req, 1);
    check("t6_underrun_pre", underrun_count, 1);
    reset_n = 1'b0;
    #1;
    check("t6_req_async",  voice_req, 0);
    check("t6_busy_async", busy, 0);
    check("t6_underrun",   underrun_count, 0);
    check("t6_left_rst",   left_out, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_idle_busy", busy, 0);
    check("t6_idle_req",  voice_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
